skip_count_ctrl: RTL and testbench
==================================

Name: skip_count_ctrl

Overview:
- Run-time controller for the skip-multiples counter datapath.
- Holds a programmable terminal value (max) and skip divisor (div), and sequences the count through start, stop, pause, free-run and one-shot modes.
- Reports lap completion (tc/done) and a saturating lap tally to the surrounding control logic.
- Replaces hard-coded skip tables with residue tracking, so any max/div pair works without a divider.

Parameters:
- W, 7, count/config width.
- DEF_MAX, 98, terminal value after reset.
- DEF_DIV, 9, skip divisor after reset.
- LAP_W, 8, width of lap tally.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept window.
- cfg_max  in  W  new terminal value.
- cfg_div  in  W  new skip divisor.
- cfg_oneshot  in  1  1 = stop after one lap.
- start  in  1  begin counting from 0.
- stop  in  1  abort and clear.
- pause  in  1  level; freeze while high.
- cnt  out  W  current count.
- busy  out  1  state is RUN or HOLD.
- tc  out  1  one-cycle lap-complete pulse.
- done  out  1  one-shot finished (level).
- laps  out  LAP_W  completed laps, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, residue=0, tc=0, done=0, laps=0.
  - max=DEF_MAX, div=DEF_DIV, oneshot=0.
- States: IDLE, RUN, HOLD, DONE.
- Config handshake:
  - cfg_ready=1 only in IDLE or DONE.
  - Registers load on the edge where cfg_valid&&cfg_ready; no effect on cnt.
  - cfg_valid in RUN/HOLD is ignored and not queued.
- Command priority: stop > start > pause.
- IDLE/DONE, start=1 -> RUN:
  - cnt=0, residue=0, laps=0, done=0.
  - First increment happens on the following edge.
- RUN, pause=1 -> HOLD: cnt and residue frozen. HOLD, pause=0 -> RUN.
- RUN/HOLD, stop=1 -> IDLE: cnt=0, residue=0; laps kept, done stays 0.
- Step rule (RUN, one step per clock):
  - Skipping is active only when div>=2; div 0 or 1 means plain +1.
  - If skipping is active and residue+1==div: nxt=cnt+2, nres=1.
  - Otherwise: nxt=cnt+1, nres=residue+1.
  - residue always equals cnt mod div.
  - All comparisons use W+1 bits, so no overflow aliasing.
- Terminal: nxt>max (compared at W+1 bits).
  - Free-run: cnt<=0, residue<=0, tc<=1 for one cycle, laps<=laps+1 saturating at all-ones.
  - One-shot: state<=DONE, cnt holds its last value, tc<=1 one cycle, laps+1, done<=1 until next start or reset.
- A max that is itself a skipped value ends the lap early.
  - Example: max=18, div=9 gives lap 0..17, 19>18 wraps.
- max=0: cnt stays 0, tc every cycle (free-run) or DONE after one cycle (one-shot).
- tc is registered and is 0 in IDLE/HOLD/DONE except its single cycle.
- busy is combinational from state.
- Reset mid-operation aborts immediately with the reset values above; config returns to defaults.

Decomposition:
- Package skip_count_pkg holds:
  - state enum (IDLE, RUN, HOLD, DONE);
  - DEF_MAX and DEF_DIV constants;
  - a step-result struct {nxt, nres, term}.
- One sub-module, skip_step: purely combinational next-value/residue/terminal calculator from cnt, residue, max, div.
- FSM, config registers and lap tally live in the top module.

Test Plan:
- Defaults, start, free-run 200 cycles:
  - sequence goes 0..8, 10..17, 19..., 89, 91..98 then 0; 89 distinct values per lap.
  - tc high exactly in the cycle cnt returns to 0; laps=1 after first wrap.
- Config max=20, div=5, oneshot=1, start:
  - sequence 0,1,2,3,4,6,...,9,11,...,14,16,...,19, then done=1 with cnt=19.
  - one tc pulse; cfg_ready=1 in DONE.
- Pause:
  - pause high 5 cycles at cnt=7 -> cnt stays 7, busy=1.
  - release -> 8 then 10.
- Priority:
  - start+stop together in RUN -> IDLE, cnt=0.
  - pause+start in IDLE -> RUN.
- Config during RUN ignored:
  - cfg_valid with max=10 while running -> cfg_ready=0; lap still ends at 98.
- div=0, max=3 free-run -> 0,1,2,3,0 with tc each wrap.
- Async reset asserted mid-lap at cnt=50 -> immediately cnt=0, IDLE, max=98, laps=0.

Source files
------------

// File: rtl/skip_count_pkg.sv
// skip_count_pkg: shared state encoding, reset defaults and step-result type for the skip counter.
package skip_count_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  localparam int CW = 7;
  localparam int DEF_MAX = 98;
  localparam int DEF_DIV = 9;
  // Step fields are sized for the default count width; the top's W must equal CW.
  typedef struct packed {
    logic [CW-1:0] nxt;
    logic [CW-1:0] nres;
    logic          term;
  } step_t;
endpackage

// File: rtl/skip_count_ctrl_step.sv
// skip_step: combinational next count, next residue and lap-terminal flag for one RUN step.
module skip_step
  import skip_count_pkg::*;
#(
  parameter int W = CW
) (
  input  logic [W-1:0] i_cnt,
  input  logic [W-1:0] i_res,
  input  logic [W-1:0] i_max,
  input  logic [W-1:0] i_div,
  output step_t        o_step
);
  logic [W:0] w_res1;
  logic [W:0] w_nxt;
  logic       w_hit;
  // One extra bit keeps cnt+2 from wrapping below max near the top of the range.
  always_comb begin
    w_res1      = {1'b0, i_res} + (W+1)'(1);
    w_hit       = (i_div > W'(1)) && (w_res1 == {1'b0, i_div});
    w_nxt       = {1'b0, i_cnt} + (w_hit ? (W+1)'(2) : (W+1)'(1));
    o_step.nxt  = w_nxt[W-1:0];
    o_step.nres = w_hit ? W'(1) : w_res1[W-1:0];
    o_step.term = w_nxt > {1'b0, i_max};
  end
endmodule

// File: rtl/skip_count_ctrl.sv
// skip_count_ctrl: run-time sequencer for the skip-multiples counter with config handshake and lap tally.
module skip_count_ctrl
  import skip_count_pkg::*;
#(
  parameter int W       = skip_count_pkg::CW,
  parameter int DEF_MAX = skip_count_pkg::DEF_MAX,
  parameter int DEF_DIV = skip_count_pkg::DEF_DIV,
  parameter int LAP_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [W-1:0]     cfg_max,
  input  logic [W-1:0]     cfg_div,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic [W-1:0]     cnt,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [LAP_W-1:0] laps
);
  state_t           r_state;
  logic [W-1:0]     r_cnt;
  logic [W-1:0]     r_res;
  logic [W-1:0]     r_max;
  logic [W-1:0]     r_div;
  logic             r_one;
  logic             r_tc;
  logic             r_done;
  logic [LAP_W-1:0] r_laps;
  step_t            w_step;

  skip_step #(.W(W)) u_step (
    .i_cnt  (r_cnt),
    .i_res  (r_res),
    .i_max  (r_max),
    .i_div  (r_div),
    .o_step (w_step)
  );

  assign busy      = (r_state == RUN) || (r_state == HOLD);
  assign cfg_ready = (r_state == IDLE) || (r_state == DONE);
  assign cnt       = r_cnt;
  assign tc        = r_tc;
  assign done      = r_done;
  assign laps      = r_laps;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_res   <= '0;
      r_max   <= W'(DEF_MAX);
      r_div   <= W'(DEF_DIV);
      r_one   <= 1'b0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_laps  <= '0;
    end else begin
      r_tc <= 1'b0;
      if (cfg_valid && cfg_ready) begin
        r_max <= cfg_max;
        r_div <= cfg_div;
        r_one <= cfg_oneshot;
      end
      // stop outranks start everywhere, so a stop in IDLE/DONE just swallows a start.
      if (stop) begin
        if (busy) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_res   <= '0;
        end
      end else if (start) begin
        r_state <= RUN;
        r_cnt   <= '0;
        r_res   <= '0;
        r_laps  <= '0;
        r_done  <= 1'b0;
      end else if (r_state == RUN && pause) begin
        r_state <= HOLD;
      end else if (r_state == HOLD && !pause) begin
        r_state <= RUN;
      end else if (r_state == RUN) begin
        if (w_step.term) begin
          r_tc   <= 1'b1;
          r_laps <= &r_laps ? r_laps : r_laps + LAP_W'(1);
          if (r_one) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= '0;
            r_res <= '0;
          end
        end else begin
          r_cnt <= w_step.nxt;
          r_res <= w_step.nres;
        end
      end
    end
  end
endmodule

// File: tb/tb_skip_count_ctrl.sv
// tb_skip_count_ctrl: scoreboard bench with an arithmetic reference model of the skip counter.
module tb_skip_count_ctrl;
  localparam int W  = 7;
  localparam int LW = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_oneshot = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [W-1:0] cfg_max = '0, cfg_div = '0;
  logic cfg_ready, busy, tc, done;
  logic [W-1:0] cnt;
  logic [LW-1:0] laps;

  typedef struct packed {
    logic [W-1:0]  cnt;
    logic          tc;
    logic          done;
    logic [LW-1:0] laps;
    logic          busy;
    logic          ready;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int n_checks = 0, n_fail = 0;

  // Model: mode 0 idle, 1 counting, 2 paused, 3 finished one-shot.
  int m_mode = 0, m_cnt = 0, m_laps = 0, m_max = 98, m_div = 9, m_nxt = 0;
  bit m_one = 0, m_tc = 0, m_done = 0, m_cfg_ok = 0;

  skip_count_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_max(cfg_max), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
    .start(start), .stop(stop), .pause(pause), .cnt(cnt), .busy(busy),
    .tc(tc), .done(done), .laps(laps)
  );

  always #5 clk = ~clk;

  // Next count skips any value that is a nonzero multiple of div.
  function automatic int next_val(input int c, input int d);
    int n;
    n = c + 1;
    if (d >= 2 && n % d == 0) n = c + 2;
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_mode = 0; m_cnt = 0; m_laps = 0; m_max = 98; m_div = 9;
      m_one = 0; m_tc = 0; m_done = 0;
    end else begin
      m_cfg_ok = (m_mode == 0 || m_mode == 3);
      m_tc = 0;
      if (stop) begin
        if (m_mode == 1 || m_mode == 2) begin m_mode = 0; m_cnt = 0; end
      end else if (start) begin
        m_mode = 1; m_cnt = 0; m_laps = 0; m_done = 0;
      end else if (m_mode == 1 && pause) m_mode = 2;
      else if (m_mode == 2 && !pause) m_mode = 1;
      else if (m_mode == 1) begin
        m_nxt = next_val(m_cnt, m_div);
        if (m_nxt > m_max) begin
          m_tc = 1;
          m_laps = (m_laps < 255) ? m_laps + 1 : 255;
          if (m_one) begin m_mode = 3; m_done = 1; end
          else m_cnt = 0;
        end else m_cnt = m_nxt;
      end
      if (cfg_valid && m_cfg_ok) begin
        m_max = int'(cfg_max); m_div = int'(cfg_div); m_one = cfg_oneshot;
      end
    end
    exp_q.push_back('{cnt: W'(m_cnt), tc: m_tc, done: m_done, laps: LW'(m_laps),
                      busy: (m_mode == 1 || m_mode == 2), ready: (m_mode == 0 || m_mode == 3)});
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{cnt: cnt, tc: tc, done: done, laps: laps, busy: busy, ready: cfg_ready};
      n_checks++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got cnt=%0d tc=%0b done=%0b laps=%0d busy=%0b ready=%0b, expected cnt=%0d tc=%0b done=%0b laps=%0d busy=%0b ready=%0b",
                 $time, mon_a.cnt, mon_a.tc, mon_a.done, mon_a.laps, mon_a.busy, mon_a.ready,
                 mon_e.cnt, mon_e.tc, mon_e.done, mon_e.laps, mon_e.busy, mon_e.ready);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg(input int mx, input int dv, input bit os);
    cfg_valid = 1; cfg_max = W'(mx); cfg_div = W'(dv); cfg_oneshot = os;
    tick();
    cfg_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic pulse_stop();
    stop = 1; tick(); stop = 0;
  endtask

  task automatic first_wrap(input string nm, input int budget, input int exp_at);
    int at;
    at = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (tc && at == 0) begin
        at = i;
        check({nm, "_cnt"}, int'(cnt), 0);
        check({nm, "_laps"}, int'(laps), 1);
      end
    end
    check({nm, "_cycle"}, at, exp_at);
  endtask

  initial begin
    int ntc;
    bit found;
    #1 rst = 0;
    repeat (3) tick();
    check("rst_cnt", int'(cnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cfg_ready), 1);
    check("rst_laps", int'(laps), 0);
    rst = 1;
    tick();

    // Defaults, free-run; offers during RUN must be refused.
    pulse_start();
    for (int i = 1; i <= 10; i++) begin
      cfg_valid = 1; cfg_max = 10; cfg_div = 3;
      tick();
      check("run_cfg_ready", int'(cfg_ready), 0);
    end
    cfg_valid = 0;
    first_wrap("def_wrap", 190, 79);
    pulse_stop();
    check("stop_cnt", int'(cnt), 0);
    check("stop_busy", int'(busy), 0);

    // One-shot 20/5.
    cfg(20, 5, 1);
    pulse_start();
    ntc = 0;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (tc) ntc++;
      if (done) found = 1;
    end
    check("oneshot_reached", int'(found), 1);
    repeat (3) begin tick(); if (tc) ntc++; end
    check("oneshot_tc_count", ntc, 1);
    check("oneshot_cnt", int'(cnt), 19);
    check("oneshot_ready", int'(cfg_ready), 1);

    // Pause at 7.
    cfg(98, 9, 0);
    pulse_start();
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (cnt == 7) found = 1; else tick();
    end
    check("reach_cnt7", int'(found), 1);
    pause = 1;
    repeat (5) tick();
    check("pause_cnt", int'(cnt), 7);
    check("pause_busy", int'(busy), 1);
    pause = 0;
    repeat (2) tick();
    check("resume_cnt8", int'(cnt), 8);
    tick();
    check("resume_cnt10", int'(cnt), 10);

    // Priority.
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    check("prio_stop_cnt", int'(cnt), 0);
    check("prio_stop_busy", int'(busy), 0);
    start = 1; pause = 1; tick(); start = 0; pause = 0;
    check("prio_start_busy", int'(busy), 1);
    check("prio_start_ready", int'(cfg_ready), 0);
    pulse_stop();

    // div=0, max=3.
    cfg(3, 0, 0);
    pulse_start();
    check("div0_cnt0", int'(cnt), 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("div0_cnt", int'(cnt), i % 4);
      check("div0_tc", int'(tc), int'(i % 4 == 0));
    end
    pulse_stop();

    // max=0: tc every cycle, laps saturates.
    cfg(0, 5, 0);
    pulse_start();
    repeat (300) tick();
    check("max0_laps_sat", int'(laps), 255);
    check("max0_tc", int'(tc), 1);
    check("max0_cnt", int'(cnt), 0);
    pulse_stop();
    check("stop_keeps_laps", int'(laps), 255);
    cfg(0, 0, 1);
    pulse_start();
    tick();
    check("max0_oneshot_done", int'(done), 1);
    check("max0_oneshot_laps", int'(laps), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      stop = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 29) == 0);
      pause = ($urandom_range(0, 4) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_max = ($urandom_range(0, 9) == 0) ? W'(127) : W'($urandom_range(0, 40));
      cfg_div = W'($urandom_range(0, 12));
      cfg_oneshot = 1'($urandom_range(0, 1));
      tick();
    end
    stop = 0; start = 0; pause = 0; cfg_valid = 0;
    pulse_stop();

    // Async reset mid-lap restores defaults.
    cfg(60, 4, 0);
    pulse_start();
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (laps == 1 && cnt == 50) found = 1; else tick();
    end
    check("reach_cnt50", int'(found), 1);
    rst = 0;
    #1;
    check("async_cnt", int'(cnt), 0);
    check("async_busy", int'(busy), 0);
    check("async_ready", int'(cfg_ready), 1);
    check("async_laps", int'(laps), 0);
    repeat (2) tick();
    rst = 1;
    pulse_start();
    first_wrap("post_rst_wrap", 120, 89);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
